// File: rtl/seven_segment_scanner_pkg.sv
// rtl/seven_segment_scanner_pkg.sv - shared constants and types for the 7-segment scanner
package seven_segment_scanner_pkg;

  // All segments dark on an active-low display
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Segment bit positions within seg
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Part of a digit slot: leading dead time or visible
  typedef enum logic {
    SLOT_DEAD = 1'b0,
    SLOT_SHOW = 1'b1
  } slot_phase_t;

endpackage

// File: rtl/seven_segment_scanner_if.sv
// rtl/seven_segment_scanner_if.sv - image load and display drive bundle
interface seven_segment_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    lz_suppress;
  logic                    load;
  logic                    update_pending;
  logic                    frame_tick;
  logic [6:0]              seg;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   an;

  modport master (
    output value, dp, blank, lz_suppress, load,
    input  update_pending, frame_tick, seg, dp_n, an
  );

  modport slave (
    input  value, dp, blank, lz_suppress, load,
    output update_pending, frame_tick, seg, dp_n, an
  );
endinterface

// File: rtl/seven_segment_scanner_decoder.sv
// rtl/seven_segment_scanner_decoder.sv - hex nibble to active-low 7-segment pattern
module seven_segment_scanner_decoder
  import seven_segment_scanner_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Pure lookup; a lit segment is driven low
  always_comb begin
    seg = SEG_OFF;
    case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// rtl/seven_segment_scanner.sv - double-buffered multiplexed N-digit 7-segment scanner
module seven_segment_scanner
  import seven_segment_scanner_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input logic                  clk,
  input logic                  rst_n,
  seven_segment_scanner_if.slave bus
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  if (PRESCALE < 2) begin : g_bad_prescale
    $error("PRESCALE must be at least 2");
  end
  if (BLANK_CYCLES >= PRESCALE) begin : g_bad_blank
    $error("BLANK_CYCLES must be below PRESCALE");
  end
  if (NUM_DIGITS < 1) begin : g_bad_digits
    $error("NUM_DIGITS must be at least 1");
  end

  logic [CW-1:0] count, count_next;
  logic [IW-1:0] idx, idx_next;
  logic          restart;
  logic          frame_start;
  logic          frame_tick_q;

  logic [4*NUM_DIGITS-1:0] act_value, pend_value;
  logic [NUM_DIGITS-1:0]   act_dp, pend_dp;
  logic [NUM_DIGITS-1:0]   act_blank, pend_blank;
  logic                    act_lz, pend_lz;
  logic                    pending_q;

  logic [NUM_DIGITS-1:0]   suppressed;
  logic [3:0]              cur_nib;
  logic [6:0]              dec_seg;
  logic                    lit;
  slot_phase_t             phase;

  logic [NUM_DIGITS-1:0]   an_q;
  logic [6:0]              seg_q;
  logic                    dp_n_q;

  // Next slot position; the first edge after reset re-enters digit 0 so it counts as a frame start
  always_comb begin
    count_next  = count + 1'b1;
    idx_next    = idx;
    frame_start = 1'b0;
    if (restart) begin
      count_next  = '0;
      idx_next    = '0;
      frame_start = 1'b1;
    end else if (count == CW'(PRESCALE - 1)) begin
      count_next = '0;
      if (idx == IW'(NUM_DIGITS - 1)) begin
        idx_next    = '0;
        frame_start = 1'b1;
      end else begin
        idx_next = idx + 1'b1;
      end
    end
  end

  // Prescaler, digit index and frame pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count        <= '0;
      idx          <= '0;
      restart      <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      count        <= count_next;
      idx          <= idx_next;
      restart      <= 1'b0;
      frame_tick_q <= frame_start;
    end
  end

  // Pending/active images: swap only at frame start, newest load always lands in pending
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_value <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_lz    <= 1'b0;
      pending_q  <= 1'b0;
      act_value  <= '0;
      act_dp     <= '0;
      act_blank  <= '1;
      act_lz     <= 1'b0;
    end else begin
      if (frame_start && pending_q) begin
        act_value <= pend_value;
        act_dp    <= pend_dp;
        act_blank <= pend_blank;
        act_lz    <= pend_lz;
      end
      if (bus.load) begin
        pend_value <= bus.value;
        pend_dp    <= bus.dp;
        pend_blank <= bus.blank;
        pend_lz    <= bus.lz_suppress;
        pending_q  <= 1'b1;
      end else if (frame_start) begin
        pending_q <= 1'b0;
      end
    end
  end

  // Leading-zero chain from the top digit down; digit 0 always shows
  always_comb begin
    logic above;
    suppressed = '0;
    above      = act_lz;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      suppressed[i] = above && (act_value[4*i +: 4] == 4'h0) && !act_dp[i];
      above         = suppressed[i];
    end
    suppressed[0] = 1'b0;
  end

  // Current digit selection and slot phase
  always_comb begin
    cur_nib = act_value[4*int'(idx) +: 4];
    lit     = !(act_blank[idx] || suppressed[idx]);
    phase   = (count < CW'(BLANK_CYCLES)) ? SLOT_DEAD : SLOT_SHOW;
  end

  seven_segment_scanner_decoder u_decoder (
    .hex (cur_nib),
    .seg (dec_seg)
  );

  // Registered display drive; anodes, segments and point always change together
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_q   <= '1;
      seg_q  <= SEG_OFF;
      dp_n_q <= 1'b1;
    end else if (phase == SLOT_SHOW && lit) begin
      an_q   <= ~(NUM_DIGITS'(1) << idx);
      seg_q  <= dec_seg;
      dp_n_q <= ~act_dp[idx];
    end else begin
      an_q   <= '1;
      seg_q  <= SEG_OFF;
      dp_n_q <= 1'b1;
    end
  end

  assign bus.an             = an_q;
  assign bus.seg            = seg_q;
  assign bus.dp_n           = dp_n_q;
  assign bus.frame_tick     = frame_tick_q;
  assign bus.update_pending = pending_q;

endmodule
